// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the ALU arbiter: FSM states, ALU in_sel
// encodings, datapath widths and the one-hot op test.
package alu_arb_pkg;

    localparam int DATA_W = 8;
    localparam int OP_W   = 7;

    // ALU in_sel encodings, {persist, load, reset}
    localparam logic [2:0] IN_SEL_RESET   = 3'b001;
    localparam logic [2:0] IN_SEL_LOAD    = 3'b010;
    localparam logic [2:0] IN_SEL_PERSIST = 3'b100;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_IDLE  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_RESP  = 3'd4
    } state_e;

    // True when exactly one bit of the op is set; clearing the lowest set
    // bit must leave nothing behind.
    function automatic logic isOneHot(input logic [OP_W-1:0] op);
        return (op != '0) && ((op & (op - OP_W'(1))) == '0);
    endfunction

endpackage

// File: rtl/alu_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin grant. The search starts at ptr and
// wraps modulo NREQ; the first requester found wins.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_id,
    output logic            any
);

    localparam logic [IDW:0] NREQ_W = (IDW+1)'(NREQ);

    logic [IDW:0] cand;

    // Walk candidates from farthest to nearest so the nearest valid one overwrites the rest
    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        any    = 1'b0;
        cand   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = {1'b0, ptr} + (IDW+1)'(k);
            if (cand >= NREQ_W) begin
                cand = cand - NREQ_W;
            end
            if (req[cand[IDW-1:0]]) begin
                gnt                 = '0;
                gnt[cand[IDW-1:0]]  = 1'b1;
                gnt_id              = cand[IDW-1:0];
                any                 = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sequencer sharing one 8-bit ALU among NREQ clients.
// Each accepted request is loaded into the ALU, held for ALU_LAT cycles, and
// returned with its requester id on a valid/ready response channel.
// Build macro ALU_ARB_OPCHECK_EN: when defined, ops that are not one-hot are
// answered straight away with rsp_err=1 and never reach the ALU.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter  int NREQ    = 4,
    parameter  int ALU_LAT = 1,
    localparam int IDW     = (NREQ <= 2) ? 1 : $clog2(NREQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [DATA_W*NREQ-1:0] req_num1,
    input  logic [DATA_W*NREQ-1:0] req_num2,
    input  logic [OP_W*NREQ-1:0]   req_op,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [IDW-1:0]         rsp_id,
    output logic [DATA_W-1:0]      rsp_data,
    output logic                   rsp_err,
    output logic                   busy,
    output logic                   alu_on,
    output logic [2:0]             alu_in_sel,
    output logic [DATA_W-1:0]      alu_num1,
    output logic [DATA_W-1:0]      alu_num2,
    output logic [OP_W-1:0]        alu_out_sel,
    input  logic [DATA_W-1:0]      alu_out
);

    localparam logic [2:0]     LAT_LAST = 3'(ALU_LAT - 1);
    localparam logic [IDW-1:0] LAST_ID  = IDW'(NREQ - 1);

    state_e            state_q, state_d;
    logic [IDW-1:0]    rrPtr_q, rrPtr_d;
    logic [IDW-1:0]    gntId_q, gntId_d;
    logic [2:0]        latCnt_q, latCnt_d;
    logic [DATA_W-1:0] num1_q, num1_d;
    logic [DATA_W-1:0] num2_q, num2_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [DATA_W-1:0] rspData_q, rspData_d;
`ifdef ALU_ARB_OPCHECK_EN
    logic              rspErr_q, rspErr_d;
`endif

    logic [NREQ-1:0]   arbGnt;
    logic [IDW-1:0]    arbId;
    logic              arbAny;
    logic              accept;

    logic [DATA_W-1:0] num1Arr [NREQ];
    logic [DATA_W-1:0] num2Arr [NREQ];
    logic [OP_W-1:0]   opArr   [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign num1Arr[i] = req_num1[i*DATA_W +: DATA_W];
        assign num2Arr[i] = req_num2[i*DATA_W +: DATA_W];
        assign opArr[i]   = req_op[i*OP_W +: OP_W];
    end

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr (
        .req    (req_valid),
        .ptr    (rrPtr_q),
        .gnt    (arbGnt),
        .gnt_id (arbId),
        .any    (arbAny)
    );

    // Grants are only offered from IDLE with en high, so a response handshake never overlaps an accept
    assign accept    = (state_q == ST_IDLE) && en && arbAny;
    assign req_ready = accept ? arbGnt : '0;

    // Next-state logic: walk the load / wait / respond sequence for one request at a time
    always_comb begin
        state_d   = state_q;
        rrPtr_d   = rrPtr_q;
        gntId_d   = gntId_q;
        latCnt_d  = latCnt_q;
        num1_d    = num1_q;
        num2_d    = num2_q;
        op_d      = op_q;
        rspData_d = rspData_q;
`ifdef ALU_ARB_OPCHECK_EN
        rspErr_d  = rspErr_q;
`endif
        case (state_q)
            ST_INIT: begin
                state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (accept) begin
                    gntId_d = arbId;
                    num1_d  = num1Arr[arbId];
                    num2_d  = num2Arr[arbId];
                    op_d    = opArr[arbId];
`ifdef ALU_ARB_OPCHECK_EN
                    if (!isOneHot(opArr[arbId])) begin
                        rspErr_d  = 1'b1;
                        rspData_d = '0;
                        state_d   = ST_RESP;
                    end else begin
                        rspErr_d  = 1'b0;
                        state_d   = ST_ISSUE;
                    end
`else
                    state_d = ST_ISSUE;
`endif
                end
            end
            ST_ISSUE: begin
                latCnt_d = '0;
                state_d  = ST_WAIT;
            end
            ST_WAIT: begin
                if (latCnt_q == LAT_LAST) begin
                    rspData_d = alu_out;
                    state_d   = ST_RESP;
                end else begin
                    latCnt_d = latCnt_q + 3'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rrPtr_d = (gntId_q == LAST_ID) ? '0 : gntId_q + IDW'(1);
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // State registers; reset discards any in-flight operation and restarts from INIT
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_INIT;
            rrPtr_q   <= '0;
            gntId_q   <= '0;
            latCnt_q  <= '0;
            num1_q    <= '0;
            num2_q    <= '0;
            op_q      <= '0;
            rspData_q <= '0;
`ifdef ALU_ARB_OPCHECK_EN
            rspErr_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            rrPtr_q   <= rrPtr_d;
            gntId_q   <= gntId_d;
            latCnt_q  <= latCnt_d;
            num1_q    <= num1_d;
            num2_q    <= num2_d;
            op_q      <= op_d;
            rspData_q <= rspData_d;
`ifdef ALU_ARB_OPCHECK_EN
            rspErr_q  <= rspErr_d;
`endif
        end
    end

    // ALU control: reset pulse in INIT, load pulse in ISSUE, persist everywhere else
    always_comb begin
        case (state_q)
            ST_INIT:  alu_in_sel = IN_SEL_RESET;
            ST_ISSUE: alu_in_sel = IN_SEL_LOAD;
            default:  alu_in_sel = IN_SEL_PERSIST;
        endcase
    end

    // alu_on and busy are gated by the reset pin so both read 0 while reset is held
    assign alu_on      = rst;
    assign busy        = rst && (state_q != ST_IDLE);
    assign alu_num1    = num1_q;
    assign alu_num2    = num2_q;
    assign alu_out_sel = op_q;
    assign rsp_valid   = (state_q == ST_RESP);
    assign rsp_id      = gntId_q;
    assign rsp_data    = rspData_q;
`ifdef ALU_ARB_OPCHECK_EN
    assign rsp_err     = rspErr_q;
`else
    assign rsp_err     = 1'b0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed bench for alu_arbiter with a behavioural ALU and a
// response scoreboard. Covers reset, fairness, single-op latency,
// backpressure, reset mid-operation, en gating and (with
// ALU_ARB_OPCHECK_EN) op rejection.
module tb_alu_arbiter;

    localparam int NREQ    = 4;
    localparam int ALU_LAT = 1;
    localparam int IDW     = 2;

    localparam logic [6:0] OP_ADD = 7'b1000000;
    localparam logic [6:0] OP_SUB = 7'b0100000;
    localparam logic [6:0] OP_AND = 7'b0010000;
    localparam logic [6:0] OP_OR  = 7'b0001000;
    localparam logic [6:0] OP_XOR = 7'b0000100;
    localparam logic [6:0] OP_NOT = 7'b0000010;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [7:0]     data;
        logic           err;
    } rsp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              en = 1'b1;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ-1:0]   req_ready;
    logic [8*NREQ-1:0] req_num1 = '0;
    logic [8*NREQ-1:0] req_num2 = '0;
    logic [7*NREQ-1:0] req_op = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b1;
    logic [IDW-1:0]    rsp_id;
    logic [7:0]        rsp_data;
    logic              rsp_err;
    logic              busy;
    logic              alu_on;
    logic [2:0]        alu_in_sel;
    logic [7:0]        alu_num1;
    logic [7:0]        alu_num2;
    logic [6:0]        alu_out_sel;
    logic [7:0]        aluOutQ = 8'h00;

    rsp_t expQ[$];
    int   grantIds[$];
    int   grantCycles[$];
    int   compareCount = 0;
    int   failCount = 0;
    int   cycleCnt = 0;
    int   loadCount = 0;

    alu_arbiter #(
        .NREQ    (NREQ),
        .ALU_LAT (ALU_LAT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_num1    (req_num1),
        .req_num2    (req_num2),
        .req_op      (req_op),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_data    (rsp_data),
        .rsp_err     (rsp_err),
        .busy        (busy),
        .alu_on      (alu_on),
        .alu_in_sel  (alu_in_sel),
        .alu_num1    (alu_num1),
        .alu_num2    (alu_num2),
        .alu_out_sel (alu_out_sel),
        .alu_out     (aluOutQ)
    );

    // Free-running clock, 10 time units per period
    always #5 clk = ~clk;

    // Cycle counter used to time grants and responses
    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    function automatic logic [7:0] aluCompute(input logic [6:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_NOT:  return ~a;
            7'b0000001: return a;
            default: return 8'h00;
        endcase
    endfunction

    // Behavioural ALU with one cycle of latency from the load pulse
    always @(posedge clk) begin
        if (alu_on) begin
            if (alu_in_sel == 3'b001) aluOutQ <= 8'h00;
            else if (alu_in_sel == 3'b010) aluOutQ <= aluCompute(alu_out_sel, alu_num1, alu_num2);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Monitor: log grants, count load pulses, check ready exclusivity and score responses
    always @(negedge clk) begin : monitor
        rsp_t e;
        if (rst) begin
            for (int i = 0; i < NREQ; i++) begin
                if (req_ready[i] && req_valid[i]) begin
                    grantIds.push_back(i);
                    grantCycles.push_back(cycleCnt);
                end
            end
            if (alu_in_sel == 3'b010) loadCount++;
            checkOutput("ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
            if (rsp_valid && rsp_ready) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_rsp", 32'(rsp_valid), 32'd0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("rsp_id", 32'(rsp_id), 32'(e.id));
                    checkOutput("rsp_data", 32'(rsp_data), 32'(e.data));
                    checkOutput("rsp_err", 32'(rsp_err), 32'(e.err));
                end
            end
        end
    end

    task automatic applyStimulus(input int id, input logic [7:0] n1, input logic [7:0] n2, input logic [6:0] op);
        req_num1[id*8 +: 8] = n1;
        req_num2[id*8 +: 8] = n2;
        req_op[id*7 +: 7]   = op;
        req_valid[id]       = 1'b1;
    endtask

    task automatic pushExp(input int id, input logic [7:0] data, input logic err);
        rsp_t e;
        e.id   = IDW'(id);
        e.data = data;
        e.err  = err;
        expQ.push_back(e);
    endtask

    task automatic waitGrant(input int id, output int acceptCycle);
        acceptCycle = -1;
        for (int w = 0; w < 50; w++) begin
            @(negedge clk);
            if (req_ready[id] && req_valid[id]) begin
                acceptCycle = cycleCnt;
                break;
            end
        end
        checkOutput($sformatf("grant_seen_r%0d", id), 32'(acceptCycle >= 0), 32'd1);
        @(posedge clk); #1;
        req_valid[id] = 1'b0;
    endtask

    task automatic waitRspValid(output int seenCycle);
        seenCycle = -1;
        for (int w = 0; w < 50; w++) begin
            @(negedge clk);
            if (rsp_valid) begin
                seenCycle = cycleCnt;
                break;
            end
        end
        checkOutput("rsp_valid_seen", 32'(seenCycle >= 0), 32'd1);
    endtask

    task automatic waitDrain(input string tag);
        for (int w = 0; w < 60; w++) begin
            @(posedge clk); #1;
            if (expQ.size() == 0) break;
        end
        checkOutput(tag, 32'(expQ.size()), 32'd0);
    endtask

    // Watchdog so a stuck DUT still ends the run
    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog");
    end

    // Directed test sequence
    initial begin
        int acc;
        int rspCyc;
        logic [6:0] expOrder [5];
        expOrder = '{7'd0, 7'd1, 7'd2, 7'd3, 7'd0};

        // Reset values while rst is held low
        #2;
        checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
        checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rst_rsp_id", 32'(rsp_id), 32'd0);
        checkOutput("rst_rsp_data", 32'(rsp_data), 32'd0);
        checkOutput("rst_rsp_err", 32'(rsp_err), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_alu_on", 32'(alu_on), 32'd0);
        checkOutput("rst_in_sel", 32'(alu_in_sel), 32'b001);
        checkOutput("rst_num1", 32'(alu_num1), 32'd0);
        checkOutput("rst_num2", 32'(alu_num2), 32'd0);
        checkOutput("rst_out_sel", 32'(alu_out_sel), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_in_sel_held", 32'(alu_in_sel), 32'b001);
        rst = 1'b1;
        #1;
        checkOutput("init_in_sel", 32'(alu_in_sel), 32'b001);
        @(posedge clk); #1;
        checkOutput("idle_in_sel", 32'(alu_in_sel), 32'b100);
        checkOutput("idle_busy", 32'(busy), 32'd0);
        checkOutput("idle_alu_on", 32'(alu_on), 32'd1);

        // Fairness: all four hold valid, expect 0,1,2,3,0 one grant per ALU_LAT+3 cycles
        $display("[TB] fairness");
        grantIds.delete();
        grantCycles.delete();
        applyStimulus(0, 8'h03, 8'h05, OP_ADD);
        applyStimulus(1, 8'h13, 8'h06, OP_SUB);
        applyStimulus(2, 8'h23, 8'h07, OP_AND);
        applyStimulus(3, 8'h33, 8'h08, OP_XOR);
        pushExp(0, 8'h08, 1'b0);
        pushExp(1, 8'h0D, 1'b0);
        pushExp(2, 8'h03, 1'b0);
        pushExp(3, 8'h3B, 1'b0);
        pushExp(0, 8'h08, 1'b0);
        for (int w = 0; w < 60; w++) begin
            @(posedge clk); #1;
            if (grantIds.size() >= 5) break;
        end
        req_valid = '0;
        checkOutput("fair_grant_count", 32'(grantIds.size() >= 5), 32'd1);
        for (int k = 0; k < 5; k++) begin
            checkOutput($sformatf("fair_order_%0d", k),
                        (k < grantIds.size()) ? 32'(grantIds[k]) : 32'hFFFF_FFFF, 32'(expOrder[k]));
        end
        for (int k = 1; k < 5; k++) begin
            checkOutput($sformatf("fair_spacing_%0d", k),
                        (k < grantCycles.size()) ? 32'(grantCycles[k] - grantCycles[k-1]) : 32'hFFFF_FFFF,
                        32'(ALU_LAT + 3));
        end
        waitDrain("fair_drain");

        // Single request from requester 0: 0x57 + 0x1A, one load pulse, ALU_LAT+2 latency
        $display("[TB] single request");
        loadCount = 0;
        applyStimulus(0, 8'h57, 8'h1A, OP_ADD);
        pushExp(0, 8'h71, 1'b0);
        waitGrant(0, acc);
        waitRspValid(rspCyc);
        checkOutput("single_latency", 32'(rspCyc - acc), 32'(ALU_LAT + 2));
        checkOutput("single_load_pulses", 32'(loadCount), 32'd1);
        waitDrain("single_drain");

        // Backpressure: response held 5 cycles while another requester waits
        $display("[TB] backpressure");
        rsp_ready = 1'b0;
        applyStimulus(3, 8'h0F, 8'hA0, OP_OR);
        pushExp(3, 8'hAF, 1'b0);
        waitGrant(3, acc);
        applyStimulus(2, 8'h3C, 8'h0F, OP_AND);
        pushExp(2, 8'h0C, 1'b0);
        waitRspValid(rspCyc);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            checkOutput("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            checkOutput("bp_rsp_data", 32'(rsp_data), 32'hAF);
            checkOutput("bp_rsp_id", 32'(rsp_id), 32'd3);
            checkOutput("bp_req_ready", 32'(req_ready), 32'd0);
            checkOutput("bp_busy", 32'(busy), 32'd1);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        waitGrant(2, acc);
        waitDrain("bp_drain");

        // Reset while in WAIT: response discarded, pointer back to 0
        $display("[TB] reset during wait");
        applyStimulus(1, 8'h11, 8'h22, OP_ADD);
        waitGrant(1, acc);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        checkOutput("midrst_in_sel", 32'(alu_in_sel), 32'b001);
        checkOutput("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("midrst_rsp_data", 32'(rsp_data), 32'd0);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        checkOutput("midrst_alu_on", 32'(alu_on), 32'd0);
        repeat (2) begin
            @(negedge clk);
            checkOutput("midrst_rsp_valid_held", 32'(rsp_valid), 32'd0);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        applyStimulus(2, 8'h40, 8'h02, OP_SUB);
        applyStimulus(3, 8'h81, 8'h7F, OP_XOR);
        pushExp(2, 8'h3E, 1'b0);
        pushExp(3, 8'hFE, 1'b0);
        waitGrant(2, acc);
        waitGrant(3, acc);
        waitDrain("midrst_drain");

        // en low: no grants for 10 cycles, then requester 1 before 3
        $display("[TB] enable gating");
        en = 1'b0;
        applyStimulus(1, 8'h05, 8'h03, OP_ADD);
        applyStimulus(3, 8'hF0, 8'h0F, OP_NOT);
        pushExp(1, 8'h08, 1'b0);
        pushExp(3, 8'h0F, 1'b0);
        repeat (10) begin
            @(negedge clk);
            checkOutput("en_low_req_ready", 32'(req_ready), 32'd0);
        end
        @(posedge clk); #1;
        en = 1'b1;
        waitGrant(1, acc);
        waitGrant(3, acc);
        waitDrain("en_drain");

`ifdef ALU_ARB_OPCHECK_EN
        // Non-one-hot ops are rejected without loading the ALU
        $display("[TB] op check");
        loadCount = 0;
        applyStimulus(0, 8'h12, 8'h34, 7'b0000011);
        pushExp(0, 8'h00, 1'b1);
        waitGrant(0, acc);
        waitDrain("opchk_multi_drain");
        applyStimulus(1, 8'h56, 8'h78, 7'b0000000);
        pushExp(1, 8'h00, 1'b1);
        waitGrant(1, acc);
        waitDrain("opchk_zero_drain");
        checkOutput("opchk_load_pulses", 32'(loadCount), 32'd0);
`endif

        checkOutput("final_queue_empty", 32'(expQ.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Round-robin arbiter and sequencer that shares the single 8-bit ALU (`main` datapath: `in_sel`/`num1`/`num2`/`out_sel` -> `out`) among `NREQ` requesters. Each requester presents an operand pair and a one-hot operation over a valid/ready handshake. The arbiter grants one request at a time, drives the ALU load/persist sequence, waits the ALU latency, and returns the result tagged with the requester id over a valid/ready response channel. It sits between the client blocks and the ALU instance in the top level.

## Interface
- `NREQ`, 4: number of requesters (2..8).
- `ALU_LAT`, 1: cycles from ALU load to valid `out` (1..7).
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `en` in 1: grant enable. When low, no new grants are made; an in-flight operation completes.
- `req_valid` in NREQ: per-requester request valid.
- `req_ready` out NREQ: per-requester accept; at most one bit is high.
- `req_num1` in 8*NREQ: operand 1; requester i uses bits [8i+7:8i].
- `req_num2` in 8*NREQ: operand 2, same packing.
- `req_op` in 7*NREQ: one-hot operation (ALU `out_sel` encoding), packed 7 bits per requester.
- `rsp_valid` out 1: response valid.
- `rsp_ready` in 1: response accept.
- `rsp_id` out IDW: granted requester index; IDW = max(1, clog2(NREQ)).
- `rsp_data` out 8: ALU result.
- `rsp_err` out 1: op rejected (only with the check enabled).
- `busy` out 1: high in any state except IDLE.
- `alu_on` out 1: ALU enable.
- `alu_in_sel` out 3: {persist, load, reset}.
- `alu_num1`, `alu_num2` out 8: ALU operands.
- `alu_out_sel` out 7: ALU op select.
- `alu_out` in 8: ALU result.

## Operation
- FSM states: INIT, IDLE, ISSUE, WAIT, RESP.
- **INIT**
  - Entered on reset. Drives `alu_in_sel`=3'b001 for one cycle, then goes to IDLE.
- **IDLE**
  - `alu_in_sel`=3'b100.
  - If `en` is high and any `req_valid` is high, combinationally raise `req_ready[g]` for the round-robin winner g. The search starts at pointer `rr_ptr` and wraps modulo NREQ.
  - On the accepting edge, latch g, `num1`, `num2` and `op`, then go to ISSUE.
- **ISSUE**
  - One cycle. `alu_in_sel`=3'b010; latched operands and op are driven on `alu_*`. Go to WAIT and clear `lat_cnt`.
- **WAIT**
  - `alu_in_sel`=3'b100; operands are held.
  - `lat_cnt` increments each cycle. When `lat_cnt`==ALU_LAT-1, capture `alu_out` into `rsp_data` and go to RESP.
- **RESP**
  - `rsp_valid`=1. `rsp_id`, `rsp_data` and `rsp_err` are held stable until `rsp_ready`.
  - On handshake, set `rr_ptr` = (id+1) mod NREQ and go to IDLE.
- Round-robin rules:
  - The requester granted last has the lowest priority on the next grant.
  - `rr_ptr` resets to 0.
- A requester dropping `req_valid` before it is granted is legal; no state is kept for it.
- `alu_on`=1 in every state except during reset.

## Timing
- Reset values:
  - state INIT, `rr_ptr`=0
  - `req_ready`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_data`=0, `rsp_err`=0, `busy`=0
  - `alu_on`=0, `alu_num1`/`alu_num2`=0, `alu_out_sel`=0
  - `alu_in_sel`=3'b001 (held while `rst` is low and for the INIT cycle)
- Latency:
  - Request acceptance edge to `rsp_valid` high is ALU_LAT+2 cycles.
  - Back-to-back throughput is one operation per ALU_LAT+3 cycles when `rsp_ready` is tied high.
- `req_ready` is low in every state except IDLE. No request is accepted in the same cycle as a response handshake.
- Simultaneous valids: the winner is the lowest index at or after `rr_ptr`.
- Reset asserted mid-operation: the FSM returns to INIT immediately and the in-flight response is discarded.
- `en` falling while in ISSUE, WAIT or RESP has no effect until IDLE.

## Configuration
- `ALU_ARB_OPCHECK_EN`
  - Defined: in IDLE, a granted op that is not exactly one-hot (zero bits set or more than one bit set) skips ISSUE and WAIT. The FSM goes directly to RESP with `rsp_err`=1 and `rsp_data`=8'h00, and the ALU is not loaded.
  - Undefined: the op is forwarded unchanged, `rsp_err` is tied to 0, and no check logic is built.

## Structure
- Package `alu_arb_pkg` holds:
  - the state enum
  - `IN_SEL_RESET`=3'b001, `IN_SEL_LOAD`=3'b010, `IN_SEL_PERSIST`=3'b100
  - `DATA_W`=8, `OP_W`=7
  - a one-hot check function
- One sub-module, `rr_arbiter`: combinational round-robin grant.
  - Inputs: `req[NREQ]` and `ptr`.
  - Outputs: `gnt` (one-hot), `gnt_id` and `any`.

## Test plan
- Single request: requester 0 sends `num1`=8'h57, `num2`=8'h1A, op 7'b1000000; the bench ALU model adds. Expect `alu_in_sel`=010 for exactly one cycle, then `rsp_valid` ALU_LAT+2 cycles after accept with `rsp_id`=0 and `rsp_data`=8'h71.
- Fairness: all 4 requesters hold valid continuously with `rsp_ready` tied to 1. Expect grant order 0,1,2,3,0 and one grant every 4 cycles (ALU_LAT=1).
- Backpressure: hold `rsp_ready` low for 5 cycles. Expect `rsp_valid`, `rsp_data` and `rsp_id` stable, all `req_ready` low, and `busy` high throughout.
- Reset during WAIT: drop `rst` low. Expect `rsp_valid` never asserted, `alu_in_sel`=001 and `rr_ptr`=0. The next request from requester 2 is served normally.
- `en` low with requesters 1 and 3 valid: expect no `req_ready` for 10 cycles. Raising `en` grants requester 1 first.
- With `ALU_ARB_OPCHECK_EN` defined: op 7'b0000011 gives `rsp_err`=1, `rsp_data`=0 and no load pulse on `alu_in_sel`. Op 7'b0000000 behaves the same.
